// File: rtl/ram_fifo_pkg.sv
// Shared constants, address-width helper and output FSM encoding for the
// RAM-backed FIFO controller.
package ram_fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;

   // Address bits needed to index a RAM of 'depth' words (depth is a power of two)
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Output side: empty register, read in flight, head word held for the consumer
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } out_state_e;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Write/read pointers and fill level of the RAM FIFO. The level counts words
// sitting in RAM that have not yet been fetched into the output register.
module ram_fifo_ptr
   import ram_fifo_pkg::*;
#(
   parameter int  DEPTH = DEFAULT_DEPTH,
   localparam int ADDR  = addr_width(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_fire,
   input  logic            fetch,
   output logic [ADDR-1:0] wr_ptr,
   output logic [ADDR-1:0] rd_ptr,
   output logic [ADDR:0]   level
);

   logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR:0]   level_q, level_d;

   // Pointers wrap naturally at DEPTH; level moves only when exactly one side is active
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + ADDR'(1);
      end
      if (fetch) begin
         rd_ptr_d = rd_ptr_q + ADDR'(1);
      end
      case ({wr_fire, fetch})
         2'b10:   level_d = level_q + (ADDR+1)'(1);
         2'b01:   level_d = level_q - (ADDR+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign wr_ptr = wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
   assign level  = level_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that drives an external dual-port RAM: port 1 writes, port 2
// reads. Valid/ready streams on both sides, registered head word on the output.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int  WIDTH = DEFAULT_WIDTH,
   parameter int  DEPTH = DEFAULT_DEPTH,
   localparam int ADDR  = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic [ADDR:0]    level,
   output logic             ram_en1,
   output logic             ram_rd_en1,
   output logic [ADDR-1:0]  ram_addr1,
   output logic [WIDTH-1:0] ram_data_in1,
   output logic             ram_en2,
   output logic             ram_rd_en2,
   output logic [ADDR-1:0]  ram_addr2,
   output logic [WIDTH-1:0] ram_data_in2,
   input  logic [WIDTH-1:0] ram_data_out2
);

   localparam logic [ADDR:0] FULL_LEVEL = (ADDR+1)'(DEPTH);

   logic            wr_fire;
   logic            fetch;
   logic [ADDR-1:0] wr_ptr;
   logic [ADDR-1:0] rd_ptr;

   out_state_e       state_q, state_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   ram_fifo_ptr #(
      .DEPTH (DEPTH)
   ) u_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_fire (wr_fire),
      .fetch   (fetch),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr),
      .level   (level)
   );

   // Handshakes and RAM port muxing; address/data lines rest at zero when idle
   always_comb begin
      wr_ready     = rst_n && (level != FULL_LEVEL);
      wr_fire      = wr_valid && wr_ready;
      ram_en1      = wr_fire;
      ram_rd_en1   = 1'b0;
      ram_addr1    = wr_fire ? wr_ptr : '0;
      ram_data_in1 = wr_fire ? wr_data : '0;
      fetch        = (level != '0) &&
                     ((state_q == IDLE) || ((state_q == HOLD) && rd_ready));
      ram_en2      = fetch;
      ram_rd_en2   = 1'b1;
      ram_addr2    = fetch ? rd_ptr : '0;
      ram_data_in2 = '0;
   end

   // Output FSM: fetch from RAM, capture one cycle later, hold until consumed
   always_comb begin
      state_d    = state_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      case (state_q)
         IDLE: begin
            if (fetch) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d    = HOLD;
            rd_valid_d = 1'b1;
            rd_data_d  = ram_data_out2;
         end
         HOLD: begin
            if (rd_ready) begin
               rd_valid_d = 1'b0;
               state_d    = fetch ? FETCH : IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
         end
      endcase
   end

   // FSM state and output register; an in-flight read is dropped on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural dual-port RAM attached.
// A table of per-cycle vectors covers fill and drain; hand sequences cover
// full, streaming with wraps, reset in FETCH and write-to-read latency.
module tb_ram_fifo_ctrl;
   import ram_fifo_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int ADDR  = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] wr_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;
   logic [ADDR:0]    level;
   logic             ram_en1, ram_rd_en1, ram_en2, ram_rd_en2;
   logic [ADDR-1:0]  ram_addr1, ram_addr2;
   logic [WIDTH-1:0] ram_data_in1, ram_data_in2;
   logic [WIDTH-1:0] ram_data_out2 = '0;

   logic [WIDTH-1:0] ramMem [DEPTH];

   int checkCount = 0;
   int errorCount = 0;
   int popCount   = 0;
   bit monEn      = 1'b0;

   logic [WIDTH-1:0] expQ[$];
   logic             prevValid = 1'b0;
   logic             prevReady = 1'b0;
   logic [WIDTH-1:0] prevData  = '0;

   typedef struct {
      logic             wv;
      logic [WIDTH-1:0] wd;
      logic             rr;
      logic             eWrReady;
      logic             eEn1;
      logic [ADDR-1:0]  eAddr1;
      logic             eEn2;
      logic             eRdValid;
      logic [WIDTH-1:0] eRdData;
      logic [ADDR:0]    eLevel;
   } vec_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   ram_fifo_ctrl #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .level         (level),
      .ram_en1       (ram_en1),
      .ram_rd_en1    (ram_rd_en1),
      .ram_addr1     (ram_addr1),
      .ram_data_in1  (ram_data_in1),
      .ram_en2       (ram_en2),
      .ram_rd_en2    (ram_rd_en2),
      .ram_addr2     (ram_addr2),
      .ram_data_in2  (ram_data_in2),
      .ram_data_out2 (ram_data_out2)
   );

   // Dual-port RAM: port 1 writes, port 2 reads with one cycle of latency
   always @(posedge clk) begin
      if (ram_en1 && !ram_rd_en1) ramMem[ram_addr1] <= ram_data_in1;
      if (ram_en2 && ram_rd_en2) ram_data_out2 <= ramMem[ram_addr2];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
      @(posedge clk);
      #1;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      @(negedge clk);
   endtask

   function automatic vec_t mkVec(input logic wv, input logic [WIDTH-1:0] wd, input logic rr,
                                  input logic ewr, input logic een1, input logic [ADDR-1:0] ea1,
                                  input logic een2, input logic erv, input logic [WIDTH-1:0] erd,
                                  input logic [ADDR:0] elv);
      vec_t v;
      v.wv = wv; v.wd = wd; v.rr = rr; v.eWrReady = ewr; v.eEn1 = een1; v.eAddr1 = ea1;
      v.eEn2 = een2; v.eRdValid = erv; v.eRdData = erd; v.eLevel = elv;
      return v;
   endfunction

   // Scoreboard and invariants: accepted words queued, delivered words popped in order
   always @(negedge clk) begin
      if (monEn && rst_n) begin
         if (wr_valid && wr_ready) expQ.push_back(wr_data);
         if (rd_valid && rd_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("sb_underflow", 32'(1), 32'(0));
            end else begin
               checkOutput("sb_data", 32'(rd_data), 32'(expQ.pop_front()));
               popCount++;
            end
         end
         if (prevValid && !prevReady) begin
            checkOutput("hold_valid", 32'(rd_valid), 32'(1));
            checkOutput("hold_data", 32'(rd_data), 32'(prevData));
         end
         checkOutput("level_max", 32'(level > 5'(DEPTH)), 32'(0));
         checkOutput("no_write_full", 32'(ram_en1 && (level == 5'(DEPTH))), 32'(0));
         checkOutput("en1_is_fire", 32'(ram_en1), 32'(wr_valid && wr_ready));
         prevValid = rd_valid;
         prevReady = rd_ready;
         prevData  = rd_data;
      end else begin
         prevValid = 1'b0;
      end
   end

   initial begin
      logic [WIDTH-1:0] nextData;
      int accepted;
      int guard;
      bit got;
      int en1T, en2T, rvT;

      rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_wr_ready", 32'(wr_ready), 32'(0));
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("rst_rd_data", 32'(rd_data), 32'(0));
      checkOutput("rst_level", 32'(level), 32'(0));
      checkOutput("rst_ram_en", 32'({ram_en1, ram_en2}), 32'(0));
      checkOutput("rst_ram_addr", 32'({ram_addr1, ram_addr2}), 32'(0));
      checkOutput("rst_ram_din", 32'({ram_data_in1, ram_data_in2}), 32'(0));
      checkOutput("rst_rd_sel", 32'({ram_rd_en1, ram_rd_en2}), 32'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;
      monEn = 1'b1;

      // Fill with four words while the consumer stalls, then drain
      vecs[0]  = mkVec(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 5'd0);
      vecs[1]  = mkVec(1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 8'h00, 5'd1);
      vecs[2]  = mkVec(1'b1, 8'hF1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 8'h00, 5'd1);
      vecs[3]  = mkVec(1'b1, 8'h3A, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 8'hAA, 5'd2);
      vecs[4]  = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 8'hAA, 5'd3);
      vecs[5]  = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 8'hAA, 5'd3);
      vecs[6]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 8'hAA, 5'd3);
      vecs[7]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 5'd2);
      vecs[8]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 8'h12, 5'd2);
      vecs[9]  = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 5'd1);
      vecs[10] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 8'hF1, 5'd1);
      vecs[11] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 5'd0);
      vecs[12] = mkVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 8'h3A, 5'd0);
      vecs[13] = mkVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 5'd0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].rr);
         checkOutput($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].eWrReady));
         checkOutput($sformatf("v%0d_ram_en1", i), 32'(ram_en1), 32'(vecs[i].eEn1));
         checkOutput($sformatf("v%0d_ram_addr1", i), 32'(ram_addr1), 32'(vecs[i].eAddr1));
         checkOutput($sformatf("v%0d_ram_din1", i), 32'(ram_data_in1),
                     32'(vecs[i].eEn1 ? vecs[i].wd : 8'h00));
         checkOutput($sformatf("v%0d_ram_en2", i), 32'(ram_en2), 32'(vecs[i].eEn2));
         checkOutput($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].eRdValid));
         if (vecs[i].eRdValid)
            checkOutput($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].eRdData));
         checkOutput($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].eLevel));
      end
      checkOutput("drain_idle_state", 32'(dut.state_q), 32'(IDLE));

      // Fill to full with the consumer stalled; 0x11 must be refused
      for (int i = 0; i < DEPTH + 2; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0);
         checkOutput($sformatf("full_wr_ready_%0d", i), 32'(wr_ready), 32'(i < DEPTH + 1));
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 8'h11, 1'b0);
         checkOutput("full_level", 32'(level), 32'(DEPTH));
         checkOutput("full_no_en1", 32'(ram_en1), 32'(0));
      end

      // Fetch at full while the producer is still pushing: no write that cycle
      applyStimulus(1'b1, 8'h11, 1'b1);
      checkOutput("full_fetch_wr_ready", 32'(wr_ready), 32'(0));
      checkOutput("full_fetch_en2", 32'(ram_en2), 32'(1));
      checkOutput("full_fetch_en1", 32'(ram_en1), 32'(0));

      // Stream 40 more words with both sides active
      nextData = 8'h11;
      accepted = 0;
      guard    = 0;
      while (accepted < 40 && guard < 400) begin
         applyStimulus(1'b1, nextData, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         if (wr_ready) begin
            accepted++;
            nextData++;
         end
         guard++;
      end
      checkOutput("stream_accepted", 32'(accepted), 32'(40));
      guard = 0;
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      while ((expQ.size() != 0 || rd_valid) && guard < 200) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         #1;
         guard++;
      end
      checkOutput("stream_drain_timeout", 32'(guard >= 200), 32'(0));
      checkOutput("stream_level", 32'(level), 32'(0));
      checkOutput("stream_popped", 32'(popCount), 32'(61));

      // Reset while a read is in flight
      applyStimulus(1'b1, 8'h61, 1'b0);
      applyStimulus(1'b1, 8'h62, 1'b0);
      @(posedge clk);
      #1;
      wr_data = 8'h63;
      checkOutput("rst_fetch_state", 32'(dut.state_q), 32'(FETCH));
      checkOutput("rst_fetch_level", 32'(level), 32'(1));
      #1 rst_n = 1'b0;
      monEn = 1'b0;
      #1;
      checkOutput("midrst_rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("midrst_level", 32'(level), 32'(0));
      checkOutput("midrst_ram_en", 32'({ram_en1, ram_en2}), 32'(0));
      checkOutput("midrst_wr_ready", 32'(wr_ready), 32'(0));
      expQ.delete();
      wr_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      monEn = 1'b1;
      applyStimulus(1'b1, 8'h5A, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         if (rd_valid) begin
            got = 1'b1;
            checkOutput("rst_readback", 32'(rd_data), 32'(8'h5A));
         end
      end
      checkOutput("rst_readback_timeout", 32'(got), 32'(1));

      // Write-to-read latency from empty with the consumer ready
      en1T = -1; en2T = -1; rvT = -1;
      for (int t = 0; t < 10; t++) begin
         applyStimulus((t == 0) ? 1'b1 : 1'b0, 8'h77, 1'b1);
         if (ram_en1 && en1T < 0) en1T = t;
         if (ram_en2 && en2T < 0) en2T = t;
         if (rd_valid && rvT < 0) rvT = t;
      end
      checkOutput("lat_en1_seen", 32'(en1T), 32'(0));
      checkOutput("lat_en2_after_en1", 32'(en2T - en1T), 32'(1));
      checkOutput("lat_valid_after_en2", 32'(rvT - en2T), 32'(2));

      checkOutput("final_popped", 32'(popCount), 32'(63));
      checkOutput("final_queue_empty", 32'(expQ.size()), 32'(0));
      checkOutput("final_level", 32'(level), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
